// File: rtl/exu_mdu_iter_if.sv
// Request/response bundle between the EXU issue logic and the iterative
// multiply/divide unit: one valid/ready channel in each direction.
interface exu_mdu_iter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/exu_mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add / restoring divide.
// Optional macro MDU_EARLY_OUT_EN lets trivial operand cases skip CALC/FIX.
module exu_mdu_iter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  output logic          busy,
  exu_mdu_iter_if.slave mdu
);

  localparam int CNT_W = $clog2(XLEN);

  // in_op bit positions
  localparam int OP_MUL    = 0;
  localparam int OP_MULH   = 1;
  localparam int OP_MULHSU = 2;
  localparam int OP_MULHU  = 3;
  localparam int OP_DIV    = 4;
  localparam int OP_DIVU   = 5;
  localparam int OP_REM    = 6;
  localparam int OP_REMU   = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v,
                                          input logic use_sign);
    logic [XLEN-1:0] r;
    if (use_sign && v[XLEN-1]) r = neg_x(v);
    else                       r = v;
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    res_q, res_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [7:0]         op_q, op_d;
  logic [XLEN-1:0]    opnd_q, opnd_d;
  logic [2*XLEN-1:0]  acc_q, acc_d;
  logic               neg_q, neg_d;

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                   accept;
  logic                   sgn_a, sgn_b, sa, sb;
  logic [XLEN-1:0]        a_abs, b_abs;
  logic                   req_mul, req_rem, rs2_zero;
  logic                   is_mul;
  logic [XLEN:0]          mul_sum;
  logic [XLEN:0]          div_rem_sh;
  logic                   div_ge;
  logic [XLEN-1:0]        div_diff;
  logic [2*XLEN-1:0]      prod;
  logic                   early_hit;
  logic [XLEN-1:0]        early_res;

  assign rs1_s = mdu.in_rs1;
  assign rs2_s = mdu.in_rs2;

  assign accept = !flush && (state_q == S_IDLE) && mdu.in_valid && is_onehot(mdu.in_op);

  // Operand signedness: mul treated as signed (low half is sign-agnostic).
  assign sgn_a    = mdu.in_op[OP_MUL] | mdu.in_op[OP_MULH] | mdu.in_op[OP_MULHSU]
                  | mdu.in_op[OP_DIV] | mdu.in_op[OP_REM];
  assign sgn_b    = mdu.in_op[OP_MUL] | mdu.in_op[OP_MULH]
                  | mdu.in_op[OP_DIV] | mdu.in_op[OP_REM];
  assign sa       = sgn_a & rs1_s[XLEN-1];
  assign sb       = sgn_b & rs2_s[XLEN-1];
  assign a_abs    = mag(rs1_s, sgn_a);
  assign b_abs    = mag(rs2_s, sgn_b);
  assign req_mul  = |mdu.in_op[OP_MULHU:OP_MUL];
  assign req_rem  = mdu.in_op[OP_REM] | mdu.in_op[OP_REMU];
  assign rs2_zero = (mdu.in_rs2 == '0);

`ifdef MDU_EARLY_OUT_EN
  // Divide-by-zero is checked before rs1==0 so 0/0 still yields all ones.
  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
    if (!req_mul && rs2_zero) begin
      early_hit = 1'b1;
      early_res = req_rem ? mdu.in_rs1 : '1;
    end else if (mdu.in_rs1 == '0) begin
      early_hit = 1'b1;
      early_res = '0;
    end else if ((mdu.in_op[OP_DIV] | mdu.in_op[OP_REM]) &&
                 (mdu.in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.in_rs2 == '1)) begin
      early_hit = 1'b1;
      early_res = mdu.in_op[OP_DIV] ? mdu.in_rs1 : '0;
    end
  end
`else
  assign early_hit = 1'b0;
  assign early_res = '0;
`endif

  // Datapath step terms: acc holds {hi, lo} for both multiply and divide.
  assign is_mul     = |op_q[OP_MULHU:OP_MUL];
  assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge     = (div_rem_sh >= {1'b0, opnd_q});
  assign div_diff   = div_rem_sh[XLEN-1:0] - opnd_q;
  assign prod       = neg_q ? neg_2x(acc_q) : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    tag_d   = tag_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_d   = neg_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_d  = mdu.in_op;
            tag_d = mdu.in_tag;
            cnt_d = '0;
            if (req_mul) begin
              opnd_d = a_abs;
              acc_d  = {{XLEN{1'b0}}, b_abs};
              neg_d  = sa ^ sb;
            end else begin
              opnd_d = b_abs;
              acc_d  = {{XLEN{1'b0}}, a_abs};
              neg_d  = req_rem ? sa : ((sa ^ sb) & !rs2_zero);
            end
            if (early_hit) begin
              res_d   = early_res;
              state_d = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end

        S_CALC: begin
          if (is_mul)      acc_d = {mul_sum, acc_q[XLEN-1:1]};
          else if (div_ge) acc_d = {div_diff, acc_q[XLEN-2:0], 1'b1};
          else             acc_d = {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            cnt_d   = '0;
            state_d = S_FIX;
          end
        end

        S_FIX: begin
          if (op_q[OP_MUL])
            res_d = prod[XLEN-1:0];
          else if (is_mul)
            res_d = prod[2*XLEN-1:XLEN];
          else if (op_q[OP_DIV] | op_q[OP_DIVU])
            res_d = neg_q ? neg_x(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
          else
            res_d = neg_q ? neg_x(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
          state_d = S_DONE;
        end

        S_DONE: begin
          if (mdu.out_ready) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and architecturally visible outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
    end
  end

  // Working datapath; contents only meaningful between accept and FIX
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    opnd_q <= opnd_d;
    acc_q  <= acc_d;
    neg_q  <= neg_d;
  end

  assign mdu.in_ready   = (state_q == S_IDLE);
  assign mdu.out_valid  = (state_q == S_DONE);
  assign mdu.out_result = res_q;
  assign mdu.out_tag    = tag_q;
  assign busy           = (state_q != S_IDLE);

endmodule
